// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst slave backed by a DEPTH-word RAM with programmable first-beat wait states.
// Optional per-beat range checking is compiled in with `define AVS_RANGE_CHECK_EN.
module avalon_burst_responder #(
    parameter int          DEPTH       = 256,
    parameter logic [29:0] BASE_ADDR   = 30'd0,
    parameter int          WAIT_STATES = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [29:0] i_AVS_Addr,
    input  logic [3:0]  i_AVS_ByteEn,
    input  logic        i_AVS_Read,
    output logic [31:0] o_AVS_ReadData,
    input  logic        i_AVS_Write,
    input  logic [31:0] i_AVS_WriteData,
    output logic        o_AVS_WaitRequest,
    input  logic [7:0]  i_AVS_BurstCount,
    output logic        o_Busy,
    output logic        o_Err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t      state, state_nxt;
    logic        is_wr, is_wr_nxt;
    logic [29:0] off, off_nxt;
    logic [7:0]  remain, remain_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    logic        wait_req_nxt;
    logic        beat;
    logic        in_range;
    logic [31:0] wmerge;
    logic [31:0] mem [DEPTH];

    // Offset is kept at full bus width so the range check can see beats past the window;
    // the RAM index uses only the low AW bits, which gives modulo-DEPTH aliasing otherwise.
`ifdef AVS_RANGE_CHECK_EN
    assign in_range = (off < 30'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    assign o_Busy = (state != S_IDLE);

    always_comb begin
        state_nxt    = state;
        is_wr_nxt    = is_wr;
        off_nxt      = off;
        remain_nxt   = remain;
        wcnt_nxt     = wcnt;
        wait_req_nxt = 1'b1;
        beat         = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_AVS_Read || i_AVS_Write) begin
                    is_wr_nxt  = i_AVS_Write;
                    off_nxt    = i_AVS_Addr - BASE_ADDR;
                    remain_nxt = (i_AVS_BurstCount == 8'd0) ? 8'd1 : i_AVS_BurstCount;
                    wcnt_nxt   = 4'd0;
                    // With no wait states the single stall cycle is the IDLE cycle that
                    // saw the request, so the first beat lands on the very next cycle.
                    if (WAIT_STATES == 0) begin
                        state_nxt    = S_BURST;
                        wait_req_nxt = 1'b0;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == WS_LAST) begin
                    state_nxt    = S_BURST;
                    wait_req_nxt = 1'b0;
                    wcnt_nxt     = 4'd0;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            S_BURST: begin
                wait_req_nxt = 1'b0;
                if (is_wr ? i_AVS_Write : i_AVS_Read) begin
                    beat       = 1'b1;
                    off_nxt    = off + 30'd1;
                    remain_nxt = remain - 8'd1;
                    if (remain == 8'd1) begin
                        state_nxt    = S_IDLE;
                        wait_req_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state             <= S_IDLE;
            is_wr             <= 1'b0;
            off               <= '0;
            remain            <= '0;
            wcnt              <= '0;
            o_AVS_WaitRequest <= 1'b1;
            o_AVS_ReadData    <= '0;
        end else begin
            state             <= state_nxt;
            is_wr             <= is_wr_nxt;
            off               <= off_nxt;
            remain            <= remain_nxt;
            wcnt              <= wcnt_nxt;
            o_AVS_WaitRequest <= wait_req_nxt;
            if (beat && !is_wr)
                o_AVS_ReadData <= in_range ? mem[off[AW-1:0]] : 32'd0;
        end
    end

`ifdef AVS_RANGE_CHECK_EN
    logic err;
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) err <= 1'b0;
        else          err <= beat && !in_range;
    end
    assign o_Err = err;
`else
    assign o_Err = 1'b0;
`endif

    always_comb begin
        wmerge = mem[off[AW-1:0]];
        for (int i = 0; i < 4; i++)
            if (i_AVS_ByteEn[i]) wmerge[8*i +: 8] = i_AVS_WriteData[8*i +: 8];
    end

    // RAM has no reset; a beat coinciding with reset is not committed.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_n && beat && is_wr && in_range)
            mem[off[AW-1:0]] <= wmerge;
    end

endmodule
